// File: rtl/apb_sram_pkg.sv
// Shared types, limits and elaboration helpers for the APB4 SRAM slave.
package apb_sram_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int WAIT_W        = 3;
  localparam int MAX_WAIT      = 7;
  localparam int MAX_LOCATIONS = 8192;
  localparam int PADDR_W       = 17;

  // Ceiling log2 with a floor of 1 so a single-word memory still gets an address bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit dw_legal(input int dw);
    return (dw == 8) || (dw == 16) || (dw == 32);
  endfunction

endpackage

// File: rtl/sram_byte_lane.sv
// One 8-bit lane of the SRAM: synchronous single-port, registered read data.
// Read data follows the address by one cycle; no backpressure.
module sram_byte_lane #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/apb4_sram_wait.sv
// APB4 slave over byte-lane SRAM with PSTRB writes, programmable wait states and PSLVERR on bad addresses.
// 0-wait transfer = setup + 1 access cycle; RD_WAIT/WR_WAIT add access cycles with PREADY held low.
module apb4_sram_wait
  import apb_sram_pkg::*;
#(
  parameter int APB_DWIDTH    = 32,
  parameter int NUM_LOCATIONS = 512,
  parameter int RD_WAIT       = 0,
  parameter int WR_WAIT       = 0,
  parameter int ADDR_SCHEME   = 0
) (
  input  logic                    i_pclk,
  input  logic                    i_preset,
  input  logic                    i_psel,
  input  logic                    i_penable,
  input  logic                    i_pwrite,
  input  logic [PADDR_W-1:0]      i_paddr,
  input  logic [APB_DWIDTH-1:0]   i_pwdata,
  input  logic [APB_DWIDTH/8-1:0] i_pstrb,
  output logic [APB_DWIDTH-1:0]   o_prdata,
  output logic                    o_pready,
  output logic                    o_pslverr
);

  localparam int NB    = APB_DWIDTH / 8;
  localparam int AW    = clog2(NUM_LOCATIONS);
  localparam int LG_NB = (NB == 4) ? 2 : (NB == 2) ? 1 : 0;
  localparam logic [PADDR_W-1:0] LANE_MASK = PADDR_W'(NB - 1);
  localparam logic [PADDR_W-1:0] LOC_LIMIT = PADDR_W'(NUM_LOCATIONS);
  localparam logic [WAIT_W-1:0]  RD_CNT    = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0]  WR_CNT    = WAIT_W'(WR_WAIT);

  if (!dw_legal(APB_DWIDTH) || NUM_LOCATIONS > MAX_LOCATIONS || NUM_LOCATIONS < 1) begin : g_bad_cfg
    $error("apb4_sram_wait: unsupported APB_DWIDTH or NUM_LOCATIONS");
  end
  if (RD_WAIT < 0 || RD_WAIT > MAX_WAIT || WR_WAIT < 0 || WR_WAIT > MAX_WAIT) begin : g_bad_wait
    $error("apb4_sram_wait: RD_WAIT/WR_WAIT out of range");
  end

  state_e                r_state;
  state_e                w_next;
  logic [WAIT_W-1:0]     r_cnt;
  logic [AW-1:0]         r_idx;
  logic                  r_err;
  logic                  r_write;
  logic [PADDR_W-1:0]    w_idx;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_done;
  logic [AW-1:0]         w_ram_addr;
  logic [APB_DWIDTH-1:0] w_ram_q;
  logic [NB-1:0]         w_we;

  assign w_idx   = (ADDR_SCHEME == 0) ? (i_paddr >> LG_NB) : i_paddr;
  assign w_err   = (w_idx >= LOC_LIMIT) || ((ADDR_SCHEME == 0) && ((i_paddr & LANE_MASK) != '0));
  assign w_setup = (r_state == IDLE) && i_psel && !i_penable;
  assign w_done  = (r_state == ACCESS) && i_psel && i_penable && (r_cnt == '0);

  // Setup presents the live index so read data is ready in the first access cycle.
  assign w_ram_addr = (r_state == IDLE) ? w_idx[AW-1:0] : r_idx;

  always_ff @(posedge i_pclk) begin
    if (i_preset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_next = ACCESS;
      ACCESS:  if (!i_psel || w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_write <= 1'b0;
    end else if (w_setup) begin
      r_cnt   <= i_pwrite ? WR_CNT : RD_CNT;
      r_idx   <= w_idx[AW-1:0];
      r_err   <= w_err;
      r_write <= i_pwrite;
    end else if (r_state == ACCESS && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    o_pready  = (r_state == ACCESS) && (r_cnt == '0);
    o_pslverr = o_pready && r_err;
    o_prdata  = (o_pready && !r_write && !r_err) ? w_ram_q : '0;
  end

  // A reset landing on the completing edge must drop the write.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign w_we[i] = w_done && r_write && !r_err && i_pstrb[i] && !i_preset;

    sram_byte_lane #(
      .DEPTH(NUM_LOCATIONS),
      .AW   (AW)
    ) u_lane (
      .i_clk  (i_pclk),
      .i_we   (w_we[i]),
      .i_addr (w_ram_addr),
      .i_wdata(i_pwdata[8*i +: 8]),
      .o_rdata(w_ram_q[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_apb4_sram_wait.sv
// Bench for apb4_sram_wait: three configurations share one APB bus, one select line each.
module tb_apb4_sram_wait;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        preset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [16:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata1;
  logic [7:0]  prdata2;
  logic [2:0]  pready, pslverr;

  apb4_sram_wait #(.APB_DWIDTH(32), .NUM_LOCATIONS(512), .RD_WAIT(0), .WR_WAIT(0), .ADDR_SCHEME(0)) u_dut0 (
    .i_pclk(clk), .i_preset(preset), .i_psel(psel[0]), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata0), .o_pready(pready[0]), .o_pslverr(pslverr[0]));

  apb4_sram_wait #(.APB_DWIDTH(32), .NUM_LOCATIONS(512), .RD_WAIT(3), .WR_WAIT(2), .ADDR_SCHEME(0)) u_dut1 (
    .i_pclk(clk), .i_preset(preset), .i_psel(psel[1]), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata1), .o_pready(pready[1]), .o_pslverr(pslverr[1]));

  apb4_sram_wait #(.APB_DWIDTH(8), .NUM_LOCATIONS(8192), .RD_WAIT(0), .WR_WAIT(0), .ADDR_SCHEME(1)) u_dut2 (
    .i_pclk(clk), .i_preset(preset), .i_psel(psel[2]), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata[7:0]), .i_pstrb(pstrb[0:0]),
    .o_prdata(prdata2), .o_pready(pready[2]), .o_pslverr(pslverr[2]));

  // Per-instance configuration as the model sees it.
  int dw_c  [3] = '{32, 32, 8};
  int nl_c  [3] = '{512, 512, 8192};
  int rwt_c [3] = '{0, 3, 0};
  int wwt_c [3] = '{0, 2, 0};
  int sch_c [3] = '{0, 0, 1};

  logic [31:0] mem [3][8192];

  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  int          cur_dut = -1;
  int          acc = 0;
  int          cur_waits = 0;
  bit          cur_err = 1'b0;
  bit          cur_wr = 1'b0;
  logic [31:0] cur_rdata = 32'd0;

  function automatic int idx_of(input int d, input logic [16:0] a);
    if (sch_c[d] == 1) return int'(a);
    return int'(a) / (dw_c[d] / 8);
  endfunction

  function automatic bit err_of(input int d, input logic [16:0] a);
    if (idx_of(d, a) >= nl_c[d]) return 1'b1;
    if (sch_c[d] == 0 && (int'(a) % (dw_c[d] / 8)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] dat_of(input int d);
    if (d == 0) return prdata0;
    if (d == 1) return prdata1;
    return {24'd0, prdata2};
  endfunction

  // Every cycle: outputs follow from which access cycle of which transfer we are in.
  always @(negedge clk) begin : cmp
    logic        e_rdy, e_err;
    logic [31:0] e_dat, a_dat;
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        if (cur_dut == d && acc > 0) begin
          e_rdy = ((acc - 1) >= cur_waits);
          e_err = e_rdy && cur_err;
          e_dat = (e_rdy && !cur_wr && !cur_err) ? cur_rdata : 32'd0;
        end else begin
          e_rdy = 1'b0;
          e_err = 1'b0;
          e_dat = 32'd0;
        end
        a_dat = dat_of(d);
        total++;
        if (pready[d] !== e_rdy || pslverr[d] !== e_err || a_dat !== e_dat) begin
          bad++;
          $display("FAIL cycle dut%0d t=%0t: pready=%b pslverr=%b prdata=%h, want %b %b %h",
                   d, $time, pready[d], pslverr[d], a_dat, e_rdy, e_err, e_dat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // mode 0 normal, 1 PSEL dropped in first access cycle, 2 reset in 2nd access cycle,
  // 3 reset in the completing access cycle. Call at #1 after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [16:0] a, input logic [31:0] wd,
                      input logic [3:0] sb, input int mode,
                      output int first_rdy, output logic [31:0] cap_dat, output logic cap_err);
    int waits, idx;
    bit e;
    waits     = wr ? wwt_c[d] : rwt_c[d];
    idx       = idx_of(d, a);
    e         = err_of(d, a);
    cur_dut   = d;
    acc       = 0;
    cur_waits = waits;
    cur_err   = e;
    cur_wr    = wr;
    cur_rdata = (!wr && !e) ? mem[d][idx] : 32'd0;
    psel      = 3'b000;
    psel[d]   = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = wd;
    pstrb     = sb;
    first_rdy = 0;
    cap_dat   = 32'd0;
    cap_err   = 1'b0;
    for (int k = 1; k <= waits + 1; k++) begin
      @(posedge clk);
      #1;
      acc   = k;
      paddr = a ^ 17'h1FFFF;
      if (mode == 1) begin
        psel    = 3'b000;
        penable = 1'b0;
      end else begin
        penable = 1'b1;
      end
      if ((mode == 2 && k == 2) || (mode == 3 && k == waits + 1)) preset = 1'b1;
      @(negedge clk);
      if (first_rdy == 0 && pready[d] === 1'b1) first_rdy = k;
      cap_dat = dat_of(d);
      cap_err = pslverr[d];
      if (mode == 1 || (mode == 2 && k == 2)) break;
    end
    @(posedge clk);
    #1;
    preset  = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    acc     = 0;
    cur_dut = -1;
    if (mode == 0 && wr && !e) begin
      for (int i = 0; i < dw_c[d] / 8; i++) begin
        if (sb[i]) mem[d][idx][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endtask

  initial begin
    int          fr;
    logic [31:0] cd;
    logic        ce;
    preset  = 1'b1;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8192; i++) mem[d][i] = 32'd0;

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_pready", {29'd0, pready}, 32'd0);
    chk("reset_pslverr", {29'd0, pslverr}, 32'd0);
    chk("reset_prdata0", prdata0, 32'd0);
    @(posedge clk);
    #1;
    preset = 1'b0;

    // 0-wait, byte addressed, 32-bit
    xfer(0, 1'b1, 17'h010, 32'hDEADBEEF, 4'hF, 0, fr, cd, ce);
    chk("wr0_ready_cycle", fr, 1);
    chk("wr0_slverr", {31'd0, ce}, 0);
    xfer(0, 1'b0, 17'h010, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd0_ready_cycle", fr, 1);
    chk("rd0_data", cd, 32'hDEADBEEF);
    chk("rd0_slverr", {31'd0, ce}, 0);
    xfer(0, 1'b1, 17'h010, 32'h11223344, 4'b0101, 0, fr, cd, ce);
    xfer(0, 1'b0, 17'h010, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd0_strb_merge", cd, 32'hDE22BE44);
    xfer(0, 1'b1, 17'h010, 32'hFFFFFFFF, 4'h0, 0, fr, cd, ce);
    xfer(0, 1'b0, 17'h010, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd0_strb_zero", cd, 32'hDE22BE44);
    xfer(0, 1'b0, 17'h800, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd0_range_err", {31'd0, ce}, 1);
    chk("rd0_range_data", cd, 32'd0);
    xfer(0, 1'b1, 17'h000, 32'hCAFEF00D, 4'hF, 0, fr, cd, ce);
    xfer(0, 1'b1, 17'h003, 32'hFFFFFFFF, 4'hF, 0, fr, cd, ce);
    chk("wr0_misalign_err", {31'd0, ce}, 1);
    xfer(0, 1'b0, 17'h000, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd0_after_misalign", cd, 32'hCAFEF00D);
    xfer(0, 1'b1, 17'h1FFFC, 32'h12345678, 4'hF, 0, fr, cd, ce);
    chk("wr0_high_addr_err", {31'd0, ce}, 1);
    xfer(0, 1'b1, 17'h7FC, 32'h0BADF00D, 4'hF, 0, fr, cd, ce);
    xfer(0, 1'b0, 17'h7FC, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd0_last_word", cd, 32'h0BADF00D);
    chk("rd0_last_word_err", {31'd0, ce}, 0);
    for (int i = 0; i < 8; i++)
      xfer(0, 1'b1, 17'((i * 37 % 512) * 4), (i * 32'h01010101) ^ 32'h5A00C300, 4'((i * 3) + 1), 0, fr, cd, ce);
    for (int i = 0; i < 8; i++)
      xfer(0, 1'b0, 17'((i * 37 % 512) * 4), 32'h0, 4'h0, 0, fr, cd, ce);

    // RD_WAIT=3, WR_WAIT=2
    xfer(1, 1'b1, 17'h020, 32'hA5A5A5A5, 4'hF, 0, fr, cd, ce);
    chk("wr1_ready_cycle", fr, 3);
    xfer(1, 1'b0, 17'h020, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd1_ready_cycle", fr, 4);
    chk("rd1_data", cd, 32'hA5A5A5A5);
    xfer(1, 1'b1, 17'h020, 32'h5A5A5A5A, 4'hF, 2, fr, cd, ce);
    chk("rst_mid_pready", {29'd0, pready}, 32'd0);
    chk("rst_mid_pslverr", {29'd0, pslverr}, 32'd0);
    xfer(1, 1'b0, 17'h020, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd1_after_rst_mid", cd, 32'hA5A5A5A5);
    xfer(1, 1'b1, 17'h020, 32'h5A5A5A5A, 4'hF, 3, fr, cd, ce);
    xfer(1, 1'b0, 17'h020, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd1_after_rst_last", cd, 32'hA5A5A5A5);
    xfer(1, 1'b1, 17'h020, 32'h5A5A5A5A, 4'hF, 1, fr, cd, ce);
    xfer(1, 1'b0, 17'h020, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd1_after_abort", cd, 32'hA5A5A5A5);
    xfer(1, 1'b0, 17'h802, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd1_err_ready_cycle", fr, 4);
    chk("rd1_err", {31'd0, ce}, 1);
    xfer(1, 1'b1, 17'h003, 32'h0, 4'hF, 0, fr, cd, ce);
    chk("wr1_err_ready_cycle", fr, 3);

    // 8-bit word addressed, full depth back-to-back
    for (int i = 0; i < 8192; i++)
      xfer(2, 1'b1, 17'(i), {24'd0, 8'(i)}, 4'h1, 0, fr, cd, ce);
    for (int i = 0; i < 8192; i++)
      xfer(2, 1'b0, 17'(i), 32'h0, 4'h0, 0, fr, cd, ce);
    xfer(2, 1'b0, 17'd8191, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd2_idx8191", cd, 32'h000000FF);
    chk("rd2_idx8191_err", {31'd0, ce}, 0);
    xfer(2, 1'b0, 17'h1234, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd2_idx1234", cd, 32'h00000034);
    xfer(2, 1'b0, 17'd8192, 32'h0, 4'h0, 0, fr, cd, ce);
    chk("rd2_idx8192_err", {31'd0, ce}, 1);
    chk("rd2_idx8192_data", cd, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
